als_display: RTL and testbench

- Downstream consumer of the ambient-light SPI reader's 8-bit sample (0–255, refreshed about 10 times per second).
- Converts the unsigned binary sample to three BCD digits with a sequential shift-add-3 (double-dabble) converter.
- Drives the Nexys3 4-digit multiplexed 7-segment display, with leading-zero blanking.
- Sits between the SPI reader's data output and the board's an/seg/dp pins.

---
 rtl/als_pkg.sv | 63 ++++++
 rtl/als_display_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/als_display.sv | 88 ++++++++
 tb/tb_als_display.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/als_pkg.sv
// Shared constants and types for the ambient-light display path:
// BCD layout, conversion FSM encoding and 7-segment codes.
package als_pkg;

    localparam int unsigned BIN_W     = 8;
    localparam int unsigned BCD_W     = 4;
    localparam int unsigned NUM_DIG   = 3;
    localparam int unsigned BCD_TOT_W = BCD_W * NUM_DIG;
    localparam int unsigned SR_W      = BCD_TOT_W + BIN_W;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned AN_W      = 4;

    typedef struct packed {
        logic [BCD_W-1:0] hun;
        logic [BCD_W-1:0] ten;
        logic [BCD_W-1:0] uni;
    } bcd_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Digit to active-low cathodes; non-decimal codes go dark.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (t[BIN_W + BCD_W*i +: BCD_W] >= 4'd5)
                t[BIN_W + BCD_W*i +: BCD_W] = t[BIN_W + BCD_W*i +: BCD_W] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/als_display_if.sv
// Sample input and BCD/display outputs of the ambient-light display block.
interface als_display_if;
    import als_pkg::*;

    logic [BIN_W-1:0] data;
    bcd_t             bcd;
    logic             bcd_valid;
    logic             busy;
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
    logic             dp;

    modport master (output data, input bcd, bcd_valid, busy, an, seg, dp);
    modport slave  (input data, output bcd, bcd_valid, busy, an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble),
// restarted whenever the input differs from the last converted value.
module bin2bcd_seq
    import als_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] data_i,
    output bcd_t             bcd_o,
    output logic             bcd_valid_o,
    output logic             busy_o
);

    logic [1:0]       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [BIN_W-1:0] last_q, last_d;
    logic [2:0]       iter_q, iter_d;
    bcd_t             bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // bcd_valid is raised on entry to DONE so it spans exactly the DONE cycle.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        last_d  = last_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (data_i != last_q) begin
                    sr_d    = {BCD_TOT_W'(0), data_i};
                    last_d  = data_i;
                    iter_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d   = dabble_step(sr_q);
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = bcd_t'(sr_q[SR_W-1:BIN_W]);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: rtl/als_display.sv
// Ambient-light sample to Nexys3 4-digit 7-segment display, with
// leading-zero blanking; the display only ever shows committed results.
module als_display
    import als_pkg::*;
#(
    parameter int unsigned MUX_DIV = 100_000
)(
    input  logic          clk,
    input  logic          rst_n,
    als_display_if.slave  io
);

    localparam int unsigned CNT_W = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;

    bcd_t             bcd;
    logic             bcd_valid;
    logic             busy;

    logic [CNT_W-1:0] mux_cnt_q, mux_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    bin2bcd_seq u_bin2bcd (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (io.data),
        .bcd_o       (bcd),
        .bcd_valid_o (bcd_valid),
        .busy_o      (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt_q <= '0;
            dig_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            mux_cnt_q <= mux_cnt_d;
            dig_q     <= dig_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    // an/seg are decoded from the next digit index so both switch with it.
    always_comb begin
        mux_cnt_d = mux_cnt_q + CNT_W'(1);
        dig_d     = dig_q;
        an_d      = 4'b1111;
        seg_d     = SEG_BLANK;
        if (mux_cnt_q == CNT_W'(MUX_DIV - 1)) begin
            mux_cnt_d = '0;
            dig_d     = dig_q + 2'd1;
        end
        case (dig_d)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_decode(bcd.uni);
            end
            2'd1: begin
                if (bcd.hun != 4'd0 || bcd.ten != 4'd0) begin
                    an_d  = 4'b1101;
                    seg_d = seg_decode(bcd.ten);
                end
            end
            2'd2: begin
                if (bcd.hun != 4'd0) begin
                    an_d  = 4'b1011;
                    seg_d = seg_decode(bcd.hun);
                end
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    assign io.bcd       = bcd;
    assign io.bcd_valid = bcd_valid;
    assign io.busy      = busy;
    assign io.an        = an_q;
    assign io.seg       = seg_q;
    assign io.dp        = 1'b1;

endmodule

// File: tb/tb_als_display.sv
// Directed self-checking bench for als_display with MUX_DIV = 4.
module tb_als_display;
    import als_pkg::*;

    localparam int unsigned MUX_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    always #5 clk = ~clk;

    als_display_if io ();

    als_display #(.MUX_DIV(MUX_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Wait for a bcd_valid pulse; n = cycles waited, -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (io.bcd_valid === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // Scan one full mux period and check anode/segment pairs against b.
    task automatic test_display_scan(input string name, input logic [11:0] b);
        logic [3:0] h, t, u;
        logic [6:0] exp_seg;
        int c0, c1, c2, cb, e1, e2;
        h = b[11:8]; t = b[7:4]; u = b[3:0];
        c0 = 0; c1 = 0; c2 = 0; cb = 0;
        e1 = (h != 0 || t != 0) ? 4 : 0;
        e2 = (h != 0) ? 4 : 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            case (io.an)
                4'b1110: begin c0++; exp_seg = seg_tab[u]; end
                4'b1101: begin c1++; exp_seg = seg_tab[t]; end
                4'b1011: begin c2++; exp_seg = seg_tab[h]; end
                default: begin cb++; exp_seg = 7'h7F; end
            endcase
            checks++;
            if (io.seg !== exp_seg) begin
                errors++;
                $display("FAIL %s seg an=%b: got %h expected %h", name, io.an, io.seg, exp_seg);
            end
        end
        checks++;
        if (c0 != 4) begin errors++; $display("FAIL %s digit0 cycles: got %0d expected 4", name, c0); end
        checks++;
        if (c1 != e1) begin errors++; $display("FAIL %s digit1 cycles: got %0d expected %0d", name, c1, e1); end
        checks++;
        if (c2 != e2) begin errors++; $display("FAIL %s digit2 cycles: got %0d expected %0d", name, c2, e2); end
        checks++;
        if (cb != 16 - 4 - e1 - e2) begin
            errors++;
            $display("FAIL %s blank cycles: got %0d expected %0d", name, cb, 16 - 4 - e1 - e2);
        end
        checks++;
        if (io.dp !== 1'b1) begin errors++; $display("FAIL %s dp: got %b expected 1", name, io.dp); end
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        io.data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (io.an !== 4'b1111) begin errors++; $display("FAIL reset an: got %b expected 1111", io.an); end
        checks++;
        if (io.seg !== 7'h7F) begin errors++; $display("FAIL reset seg: got %h expected 7f", io.seg); end
        checks++;
        if (io.bcd !== 12'h000) begin errors++; $display("FAIL reset bcd: got %h expected 000", io.bcd); end
        checks++;
        if (io.busy !== 1'b0 || io.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/valid: got %b/%b expected 0/0", io.busy, io.bcd_valid);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (io.bcd_valid !== 1'b0 || io.busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL idle_zero activity cycles: got %0d expected 0", pulses); end
        test_display_scan("zero", 12'h000);
    endtask

    task automatic test_173();
        int valid_at, pulses;
        logic [11:0] b;
        valid_at = -1; pulses = 0; b = 12'hFFF;
        tick();
        io.data = 8'd173;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (io.bcd_valid === 1'b1) begin
                pulses++;
                if (valid_at < 0) valid_at = k;
            end
            if (k == 10) b = io.bcd;
        end
        checks++;
        if (valid_at != 9) begin errors++; $display("FAIL latency173: got %0d expected 9", valid_at); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL pulses173: got %0d expected 1", pulses); end
        checks++;
        if (b !== 12'h173) begin errors++; $display("FAIL bcd173: got %h expected 173", b); end
        test_display_scan("d173", 12'h173);
    endtask

    task automatic test_small();
        int n;
        tick();
        io.data = 8'd7;
        wait_valid(20, n);
        checks++;
        if (n != 9) begin errors++; $display("FAIL latency7: got %0d expected 9", n); end
        tick();
        checks++;
        if (io.bcd !== 12'h007) begin errors++; $display("FAIL bcd7: got %h expected 007", io.bcd); end
        test_display_scan("d7", 12'h007);
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic prev;
        logic [11:0] got [2];
        pulses = 0; prev = 1'b0;
        got[0] = 12'hFFF; got[1] = 12'hFFF;
        tick();
        io.data = 8'd200;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3) io.data = 8'd255;
            if (prev && pulses >= 1 && pulses <= 2) got[pulses-1] = io.bcd;
            prev = io.bcd_valid;
            if (io.bcd_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL b2b pulses: got %0d expected 2", pulses); end
        checks++;
        if (got[0] !== 12'h200) begin errors++; $display("FAIL b2b first: got %h expected 200", got[0]); end
        checks++;
        if (got[1] !== 12'h255) begin errors++; $display("FAIL b2b second: got %h expected 255", got[1]); end
        test_display_scan("d255", 12'h255);
    endtask

    task automatic test_reset_mid();
        int n;
        tick();
        io.data = 8'd99;
        repeat (3) tick();
        checks++;
        if (io.busy !== 1'b1) begin errors++; $display("FAIL mid busy: got %b expected 1", io.busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (io.an !== 4'b1111 || io.seg !== 7'h7F) begin
            errors++;
            $display("FAIL mid reset an/seg: got %b/%h expected 1111/7f", io.an, io.seg);
        end
        checks++;
        if (io.bcd !== 12'h000 || io.busy !== 1'b0 || io.bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid reset bcd/busy/valid: got %h/%b/%b expected 000/0/0", io.bcd, io.busy, io.bcd_valid);
        end
        tick();
        rst_n = 1'b1;
        wait_valid(20, n);
        checks++;
        if (n != 9) begin errors++; $display("FAIL restart latency: got %0d expected 9", n); end
        tick();
        checks++;
        if (io.bcd !== 12'h099) begin errors++; $display("FAIL bcd99: got %h expected 099", io.bcd); end
        test_display_scan("d99", 12'h099);
    endtask

    task automatic test_sweep();
        int busy_n;
        bit got;
        for (int v = 0; v < 256; v++) begin
            io.data = 8'(v);
            busy_n = 0; got = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (io.busy === 1'b1) busy_n++;
                if (io.bcd_valid === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            checks++;
            if (!got) begin errors++; $display("FAIL sweep %0d timeout waiting for bcd_valid", v); end
            checks++;
            if (busy_n != 9) begin errors++; $display("FAIL sweep %0d busy cycles: got %0d expected 9", v, busy_n); end
            tick();
            checks++;
            if (io.bcd !== to_bcd(v)) begin
                errors++;
                $display("FAIL sweep %0d bcd: got %h expected %h", v, io.bcd, to_bcd(v));
            end
            checks++;
            if (io.busy !== 1'b0) begin errors++; $display("FAIL sweep %0d busy after done: got %b expected 0", v, io.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_173();
        test_small();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
